wshb_arbiter: RTL and testbench
===============================

Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the SDRAM controller.
- Lets the video frame reader (m0) and a frame-buffer writer (m1, e.g. the test-pattern/drawing engine) share the SDRAM.
- Arbitration is round-robin, with a per-grant ack quantum so a master that holds CYC continuously cannot starve the other.
- Runs entirely in the Wishbone clock domain.

Parameters:
- AW, 32, address width for all ports.
- DW, 32, data width for all ports.
- QUANTUM, 64, maximum acks per grant while the other master is requesting. 0 disables preemption.

Ports:
- clk  in  1  Wishbone clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (video reader) control.
- m0_adr  in  AW  master 0 address.
- m0_dat_ms  in  DW  master 0 write data.
- m0_sel  in  DW/8  master 0 byte select.
- m0_ack  out  1  ack to master 0.
- m0_dat_sm  out  DW  read data to master 0.
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel  in  same widths as m0  master 1 (writer).
- m1_ack  out  1  ack to master 1.
- m1_dat_sm  out  DW  read data to master 1.
- s_cyc, s_stb, s_we  out  1 each  slave control.
- s_adr  out  AW  slave address.
- s_dat_ms  out  DW  slave write data.
- s_sel  out  DW/8  slave byte select.
- s_ack  in  1  slave ack.
- s_dat_sm  in  DW  slave read data.
- gnt  out  2  one-hot current grant (debug/status). 00 = none.

Behaviour:
- Reset (async on rst_n low, released sync): state IDLE, gnt=00, last=1 (m0 wins the first tie), ack_cnt=0. s_cyc=s_stb=0, m0_ack=m1_ack=0.
- Clock and reset: everything on posedge clk.
- States:
  - IDLE: no grant.
  - G0: master 0 owns the slave.
  - G1: master 1 owns the slave.
  - Transitions occur on clock edges only.
- IDLE transitions:
  - Only m0_cyc=1 -> G0. Only m1_cyc=1 -> G1.
  - Both requesting -> grant the master != last.
  - On entering Gx: last<=x, ack_cnt<=0.
- Gx routing (combinational):
  - s_cyc=mx_cyc, s_stb=mx_stb.
  - s_we/s_adr/s_dat_ms/s_sel come from master x.
  - mx_ack=s_ack. The other master's ack is 0.
  - s_dat_sm is broadcast to both mN_dat_sm at all times.
- IDLE outputs: s_cyc=s_stb=0. s_we, s_adr, s_dat_ms, s_sel = 0.
- Normal release: in Gx with mx_cyc=0 at the clock edge -> IDLE. Exactly one idle cycle between grants (no back-to-back switch).
- ack_cnt in Gx:
  - Increments on each cycle with s_ack=1.
  - Saturates at QUANTUM.
  - Width is clog2(QUANTUM+1), minimum 1.
- Preemption (QUANTUM>0), in Gx:
  - Triggers on a cycle where s_ack=1, ack_cnt==QUANTUM-1 and the other master's cyc=1.
  - Next edge goes to state IDLE, and the other master is granted per round-robin.
  - Preemption happens only on an ack cycle, so no classic transfer is ever abandoned mid-strobe.
  - The preempted master keeps cyc/stb high and simply sees no ack until it is re-granted.
- If the other master is not requesting when the count reaches QUANTUM, the grant continues. The count stays saturated; preemption fires on the next ack once the other master requests.
- Simultaneous events:
  - mx_cyc falling on the same cycle as the preemption condition -> IDLE (same result either way).
  - s_ack while in IDLE is ignored and not forwarded.
- Reset mid-transfer: immediately returns to IDLE with all outputs deasserted. In-flight slave acks are dropped.
- Latency: no added latency on the granted path (pure mux). Grant latency from IDLE is 1 cycle.

Test Plan:
- Single master: m0 holds cyc/stb for 10 transfers, slave acks every cycle -> gnt=01 one cycle after cyc, m0_ack matches s_ack 10 times, m1_ack=0 throughout.
- Tie after reset: m0_cyc and m1_cyc rise together -> G0 first (gnt=01). After m0 drops cyc: one cycle with gnt=00, then gnt=10.
- Quantum: QUANTUM=4, both masters hold cyc continuously, slave acks every cycle. Expected grant sequence: m0 gets 4 acks, 1 idle cycle, m1 gets 4 acks, 1 idle cycle, m0 ... Checked for 3 rounds; addresses on s_adr come from the granted master only.
- Quantum with no contender: QUANTUM=4, only m0 requests for 20 acks -> no preemption. m1 raises cyc at ack 20 -> switch after the next m0 ack.
- Wait states: slave inserts 3 wait cycles per ack, and m1 requests during m0's stall at ack_cnt=QUANTUM-1 -> no switch until s_ack arrives, and m0's strobe is never cut off.
- Async reset during G1 with stb high -> s_cyc, s_stb and gnt go to 0 within the same cycle, without waiting for a clock edge. After release, state is IDLE and last=1.

Source files
------------

// File: rtl/wshb_arbiter_if.sv
// Wishbone classic point-to-point bundle; "master" drives the request side,
// "slave" drives ack and read data.
interface wshb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_ms;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic [DW-1:0]   dat_sm;

  modport master (output cyc, stb, we, adr, dat_ms, sel, input ack, dat_sm);
  modport slave  (input cyc, stb, we, adr, dat_ms, sel, output ack, dat_sm);
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with an ack quantum so a
// master holding CYC continuously cannot starve the other one.
module wshb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int QUANTUM = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  wshb_arbiter_if.slave  m0,
  wshb_arbiter_if.slave  m1,
  wshb_arbiter_if.master s,
  output logic [1:0]     gnt
);

  localparam int CW = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
  localparam bit PREEMPT_EN = (QUANTUM > 0);
  localparam logic [CW-1:0] Q_MAX  = CW'(QUANTUM);
  localparam logic [CW-1:0] Q_LAST = (QUANTUM > 0) ? CW'(QUANTUM - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state_r;
  logic [1:0]    gnt_r;
  logic          last_r;
  logic [CW-1:0] ack_cnt_r;

  logic own_cyc_s;
  logic other_cyc_s;
  logic preempt_s;

  // Owner/contender request lines and the quantum-expiry preemption condition
  always_comb begin
    own_cyc_s   = 1'b0;
    other_cyc_s = 1'b0;
    case (state_r)
      G0: begin
        own_cyc_s   = m0.cyc;
        other_cyc_s = m1.cyc;
      end
      G1: begin
        own_cyc_s   = m1.cyc;
        other_cyc_s = m0.cyc;
      end
      default: begin
        own_cyc_s   = 1'b0;
        other_cyc_s = 1'b0;
      end
    endcase
    // >= covers the saturated count when the contender shows up late
    if (PREEMPT_EN && s.ack && (ack_cnt_r >= Q_LAST) && other_cyc_s) begin
      preempt_s = 1'b1;
    end else begin
      preempt_s = 1'b0;
    end
  end

  // Grant FSM: state, round-robin history and per-grant ack counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= 2'b00;
      last_r    <= 1'b1;
      ack_cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last_r)) begin
            state_r   <= G0;
            gnt_r     <= 2'b01;
            last_r    <= 1'b0;
            ack_cnt_r <= {CW{1'b0}};
          end else if (m1.cyc) begin
            state_r   <= G1;
            gnt_r     <= 2'b10;
            last_r    <= 1'b1;
            ack_cnt_r <= {CW{1'b0}};
          end else begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
          end
        end
        G0, G1: begin
          if (!own_cyc_s || preempt_s) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
          end else if (s.ack && (ack_cnt_r != Q_MAX)) begin
            ack_cnt_r <= ack_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            ack_cnt_r <= ack_cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
        end
      endcase
    end
  end

  // Pure mux from the owning master to the slave; acks go only to the owner
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.adr    = {AW{1'b0}};
    s.dat_ms = {DW{1'b0}};
    s.sel    = {(DW/8){1'b0}};
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    case (state_r)
      G0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_ms = m0.dat_ms;
        s.sel    = m0.sel;
        m0.ack   = s.ack;
      end
      G1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_ms = m1.dat_ms;
        s.sel    = m1.sel;
        m1.ack   = s.ack;
      end
      default: begin
        m0.ack = 1'b0;
        m1.ack = 1'b0;
      end
    endcase
  end

  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;
  assign gnt       = gnt_r;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter (QUANTUM=4): vector table for basic routing
// and tie-breaking, hand sequences for quantum, wait states and async reset.
module tb_wshb_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_1111;
  localparam logic [3:0]  S0 = 4'h3;
  localparam logic [3:0]  S1 = 4'hC;

  logic       clk;
  logic       rst_n;
  logic [1:0] gnt;
  int         errors;
  int         checks;

  wshb_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  wshb_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  wshb_arbiter_if #(.AW(32), .DW(32)) s_if ();

  wshb_arbiter #(.AW(32), .DW(32), .QUANTUM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt   (gnt)
  );

  typedef struct {
    logic        m0_cyc;
    logic        m1_cyc;
    logic        s_ack;
    logic [1:0]  gnt;
    logic        m0_ack;
    logic        m1_ack;
    logic        s_cyc;
    logic [31:0] s_adr;
  } vec_t;

  vec_t vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic c1, input logic ack);
    m0_if.cyc = c0;
    m0_if.stb = c0;
    m1_if.cyc = c1;
    m1_if.stb = c1;
    s_if.ack  = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int n1;
    int bad;
    logic [1:0] eg;

    errors = 0;
    checks = 0;
    m0_if.we = 1'b0; m0_if.adr = A0; m0_if.dat_ms = D0; m0_if.sel = S0;
    m1_if.we = 1'b1; m1_if.adr = A1; m1_if.dat_ms = D1; m1_if.sel = S1;
    s_if.dat_sm = 32'h0;

    vecs = '{
      '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, A0},
      '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, A0},
      '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, A0},
      '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, A1},
      '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, A1},
      '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, A0},
      '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, A0},
      '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0}
    };

    // Reset state, with s_ack high to show it is not forwarded in IDLE
    do_reset();
    s_if.ack = 1'b1;
    @(negedge clk);
    chk("reset_gnt", {30'h0, gnt}, 32'h0);
    chk("reset_s_cyc", {31'h0, s_if.cyc}, 32'h0);
    chk("reset_s_stb", {31'h0, s_if.stb}, 32'h0);
    chk("reset_m0_ack", {31'h0, m0_if.ack}, 32'h0);
    chk("reset_m1_ack", {31'h0, m1_if.ack}, 32'h0);

    // Table: tie after reset, release with one idle cycle, routing
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].m0_cyc, vecs[i].m1_cyc, vecs[i].s_ack);
      s_if.dat_sm = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), {30'h0, gnt}, {30'h0, vecs[i].gnt});
      chk($sformatf("vec%0d_m0_ack", i), {31'h0, m0_if.ack}, {31'h0, vecs[i].m0_ack});
      chk($sformatf("vec%0d_m1_ack", i), {31'h0, m1_if.ack}, {31'h0, vecs[i].m1_ack});
      chk($sformatf("vec%0d_s_cyc", i), {31'h0, s_if.cyc}, {31'h0, vecs[i].s_cyc});
      chk($sformatf("vec%0d_s_stb", i), {31'h0, s_if.stb}, {31'h0, vecs[i].s_cyc});
      chk($sformatf("vec%0d_s_adr", i), s_if.adr, vecs[i].s_adr);
      chk($sformatf("vec%0d_s_we", i), {31'h0, s_if.we}, (vecs[i].gnt == 2'b10) ? 32'h1 : 32'h0);
      chk($sformatf("vec%0d_s_dat_ms", i), s_if.dat_ms,
          (vecs[i].gnt == 2'b01) ? D0 : (vecs[i].gnt == 2'b10) ? D1 : 32'h0);
      chk($sformatf("vec%0d_s_sel", i), {28'h0, s_if.sel},
          (vecs[i].gnt == 2'b01) ? {28'h0, S0} : (vecs[i].gnt == 2'b10) ? {28'h0, S1} : 32'h0);
      chk($sformatf("vec%0d_m0_dat_sm", i), m0_if.dat_sm, 32'hD000_0000 + 32'(i));
      chk($sformatf("vec%0d_m1_dat_sm", i), m1_if.dat_sm, 32'hD000_0000 + 32'(i));
      next_cycle();
    end

    // Single master, 10 back-to-back transfers
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_idle_gnt", {30'h0, gnt}, 32'h0);
    chk("single_idle_m0_ack", {31'h0, m0_if.ack}, 32'h0);
    next_cycle();
    n0 = 0; n1 = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m0_if.ack) n0++;
      if (m1_if.ack) n1++;
      if (gnt !== 2'b01) bad++;
      next_cycle();
    end
    chk("single_m0_acks", 32'(n0), 32'd10);
    chk("single_m1_acks", 32'(n1), 32'd0);
    chk("single_gnt_bad_cycles", 32'(bad), 32'd0);

    // Quantum rotation: 4 acks, idle, 4 acks, idle ... for 3 rounds
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("quant_idle_gnt", {30'h0, gnt}, 32'h0);
    next_cycle();
    for (int k = 0; k < 30; k++) begin
      eg = ((k % 10) < 4) ? 2'b01 : ((k % 10) == 4 || (k % 10) == 9) ? 2'b00 : 2'b10;
      @(negedge clk);
      chk($sformatf("quant%0d_gnt", k), {30'h0, gnt}, {30'h0, eg});
      chk($sformatf("quant%0d_s_adr", k), s_if.adr,
          (eg == 2'b01) ? A0 : (eg == 2'b10) ? A1 : 32'h0);
      chk($sformatf("quant%0d_m0_ack", k), {31'h0, m0_if.ack}, (eg == 2'b01) ? 32'h1 : 32'h0);
      chk($sformatf("quant%0d_m1_ack", k), {31'h0, m1_if.ack}, (eg == 2'b10) ? 32'h1 : 32'h0);
      next_cycle();
    end

    // No contender: 20 acks without preemption, then m1 arrives
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    next_cycle();
    n0 = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m0_if.ack) n0++;
      if (gnt !== 2'b01) bad++;
      next_cycle();
    end
    chk("nocont_m0_acks", 32'(n0), 32'd20);
    chk("nocont_gnt_bad_cycles", 32'(bad), 32'd0);
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("nocont_ack21_gnt", {30'h0, gnt}, 32'h1);
    chk("nocont_ack21_m0_ack", {31'h0, m0_if.ack}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("nocont_idle_gnt", {30'h0, gnt}, 32'h0);
    chk("nocont_idle_m0_ack", {31'h0, m0_if.ack}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("nocont_g1_gnt", {30'h0, gnt}, 32'h2);
    chk("nocont_g1_m1_ack", {31'h0, m1_if.ack}, 32'h1);
    chk("nocont_g1_s_adr", s_if.adr, A1);

    // Wait states: 3 waits per ack; m1 requests while m0 stalls at count 3
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    next_cycle();
    n0 = 0;
    for (int a = 0; a < 3; a++) begin
      for (int w = 0; w < 4; w++) begin
        s_if.ack = (w == 3) ? 1'b1 : 1'b0;
        @(negedge clk);
        if (m0_if.ack) n0++;
        next_cycle();
      end
    end
    chk("wait_setup_m0_acks", 32'(n0), 32'd3);
    drive(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk($sformatf("wait_stall%0d_gnt", w), {30'h0, gnt}, 32'h1);
      chk($sformatf("wait_stall%0d_s_stb", w), {31'h0, s_if.stb}, 32'h1);
      chk($sformatf("wait_stall%0d_s_cyc", w), {31'h0, s_if.cyc}, 32'h1);
      chk($sformatf("wait_stall%0d_s_adr", w), s_if.adr, A0);
      next_cycle();
    end
    s_if.ack = 1'b1;
    @(negedge clk);
    chk("wait_ack_gnt", {30'h0, gnt}, 32'h1);
    chk("wait_ack_m0_ack", {31'h0, m0_if.ack}, 32'h1);
    next_cycle();
    s_if.ack = 1'b0;
    @(negedge clk);
    chk("wait_idle_gnt", {30'h0, gnt}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wait_g1_gnt", {30'h0, gnt}, 32'h2);

    // Async reset in the middle of a G1 cycle, then tie resolves to m0
    do_reset();
    drive(1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("areset_pre_gnt", {30'h0, gnt}, 32'h2);
    chk("areset_pre_s_stb", {31'h0, s_if.stb}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_s_cyc", {31'h0, s_if.cyc}, 32'h0);
    chk("areset_s_stb", {31'h0, s_if.stb}, 32'h0);
    chk("areset_gnt", {30'h0, gnt}, 32'h0);
    chk("areset_m1_ack", {31'h0, m1_if.ack}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_post_idle_gnt", {30'h0, gnt}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("areset_post_tie_gnt", {30'h0, gnt}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
